// File: rtl/instr_encoder.sv
// Packs decoded ALU instruction fields into 16-bit words, buffers them in a
// small FIFO and streams them into instruction memory through a stallable port.
module instr_encoder #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic          in_imode,
  input  logic          in_setcc,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_ra,
  input  logic [2:0]    in_rb,
  input  logic [3:0]    in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] word_count,
  output logic          err_illegal
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [AW-1:0] addr_q, wcount_q;
  logic          err_q;
  logic [15:0]   last_q;

  logic [15:0]   enc;
  logic          illegal;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;

  // MOV/MOVI/NOT have no source A, so that field is zeroed in the word.
  always_comb begin
    enc        = '0;
    enc[4:0]   = {in_op, in_imode};
    enc[5]     = in_setcc;
    enc[8:6]   = in_rd;
    enc[11:9]  = in_ra;
    if (in_imode) enc[15:12] = in_imm;
    else          enc[14:12] = in_rb;
    if (in_op == 4'd2 || in_op == 4'd10) enc[11:9] = 3'b000;
    illegal = (in_op > 4'd10) || (in_op == 4'd10 && in_imode);
  end

  assign fifo_full  = (count_q == (PW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);

  assign in_ready = (state_q == RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !illegal;
  assign mem_we   = (state_q == RUN || state_q == FLUSH) && !fifo_empty;
  assign pop      = mem_we && mem_ready;

  assign mem_addr    = addr_q;
  assign mem_wdata   = fifo_empty ? last_q : fifo_q[rd_ptr_q];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign word_count  = wcount_q;
  assign err_illegal = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = FLUSH;
      FLUSH:   if (fifo_empty && !pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage array needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wcount_q <= '0;
      err_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= fifo_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (state_q == IDLE && start) begin
        addr_q   <= base_addr;
        wcount_q <= '0;
        err_q    <= 1'b0;
      end else begin
        if (pop) begin
          addr_q   <= addr_q + AW'(1);
          wcount_q <= wcount_q + AW'(1);
        end
        if (accept && illegal) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written
// sequences for backpressure, address wrap and mid-load reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, finish, in_valid, in_ready;
  logic [7:0]  base_addr;
  logic [3:0]  in_op, in_imm;
  logic        in_imode, in_setcc;
  logic [2:0]  in_rd, in_ra, in_rb;
  logic        mem_we, mem_ready, busy, done, err_illegal;
  logic [7:0]  mem_addr, word_count;
  logic [15:0] mem_wdata;

  typedef struct {
    logic [3:0]  op;
    logic        imode;
    logic        setcc;
    logic [2:0]  rd, ra, rb;
    logic [3:0]  imm;
    logic        legal;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[11];

  int checkCount = 0;
  int failCount  = 0;
  int cycle      = 0;
  int donePulses = 0;
  logic [7:0]  wrAddr[$];
  logic [15:0] wrData[$];
  int          wrCycle[$];

  instr_encoder #(.AW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imode(in_imode), .in_setcc(in_setcc),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done),
    .word_count(word_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Records every write handshake that will complete on the following edge.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
      wrCycle.push_back(cycle);
    end
    if (done) donePulses <= donePulses + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveFields(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_imode = v.imode;
    in_setcc = v.setcc;
    in_rd    = v.rd;
    in_ra    = v.ra;
    in_rb    = v.rb;
    in_imm   = v.imm;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    driveFields(v);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic startLoad(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic finishAndWait(input string name);
    logic seen;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    tick();
    @(negedge clk);
    checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
    tick();
  endtask

  function automatic vec_t mkAdd(input logic [2:0] rd, input logic [2:0] ra,
                                 input logic [2:0] rb);
    vec_t v;
    v = '{4'd0, 1'b0, 1'b0, rd, ra, rb, 4'd0, 1'b1,
          {1'b0, rb, ra, rd, 1'b0, 5'd0}};
    return v;
  endfunction

  function automatic void clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCycle.delete();
  endfunction

  initial begin
    vec_t v;
    int k;
    int pulsesBefore;

    vecs[0]  = '{4'd0,  1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 4'h0, 1'b1, 16'h3460};
    vecs[1]  = '{4'd2,  1'b1, 1'b0, 3'd7, 3'd5, 3'd0, 4'hA, 1'b1, 16'hA1C5};
    vecs[2]  = '{4'd10, 1'b0, 1'b0, 3'd4, 3'd6, 3'd5, 4'h0, 1'b1, 16'h5114};
    vecs[3]  = '{4'd10, 1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 4'h5, 1'b0, 16'h0000};
    vecs[4]  = '{4'd12, 1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 4'h0, 1'b0, 16'h0000};
    vecs[5]  = '{4'd1,  1'b1, 1'b0, 3'd2, 3'd3, 3'd7, 4'hF, 1'b1, 16'hF683};
    vecs[6]  = '{4'd7,  1'b0, 1'b1, 3'd0, 3'd7, 3'd1, 4'h0, 1'b1, 16'h1E2E};
    vecs[7]  = '{4'd9,  1'b0, 1'b0, 3'd3, 3'd1, 3'd6, 4'h0, 1'b1, 16'h62D2};
    vecs[8]  = '{4'd2,  1'b0, 1'b1, 3'd5, 3'd3, 3'd2, 4'h0, 1'b1, 16'h2164};
    vecs[9]  = '{4'd11, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 16'h0000};
    vecs[10] = '{4'd3,  1'b1, 1'b1, 3'd6, 3'd4, 3'd0, 4'h1, 1'b1, 16'h19A7};

    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    base_addr = '0; in_op = '0; in_imode = 1'b0; in_setcc = 1'b0;
    in_rd = '0; in_ra = '0; in_rb = '0; in_imm = '0; mem_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err_illegal), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single ADD load");
    clearLog();
    donePulses = 0;
    startLoad(8'h10);
    applyStimulus(vecs[0]);
    finishAndWait("t1");
    checkOutput("t1_nwrites", 32'(wrData.size()), 32'd1);
    checkOutput("t1_addr", 32'(wrAddr[0]), 32'h10);
    checkOutput("t1_data", 32'(wrData[0]), 32'h3460);
    checkOutput("t1_done_pulses", 32'(donePulses), 32'd1);
    checkOutput("t1_word_count", 32'(word_count), 32'd1);
    checkOutput("t1_err", 32'(err_illegal), 32'd0);

    $display("[TB] encoding table load");
    clearLog();
    startLoad(8'h20);
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
    finishAndWait("tbl");
    checkOutput("tbl_nwrites", 32'(wrData.size()), 32'd8);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].legal) begin
        checkOutput($sformatf("tbl_data%0d", i), 32'(wrData[k]), 32'(vecs[i].word));
        checkOutput($sformatf("tbl_addr%0d", i), 32'(wrAddr[k]), 32'h20 + 32'(k));
        k++;
      end
    end
    checkOutput("tbl_err", 32'(err_illegal), 32'd1);
    checkOutput("tbl_word_count", 32'(word_count), 32'd8);

    $display("[TB] address wrap load");
    clearLog();
    startLoad(8'hFE);
    @(negedge clk);
    checkOutput("wrap_err_cleared", 32'(err_illegal), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) applyStimulus(mkAdd(3'(i), 3'd1, 3'd2));
    finishAndWait("wrap");
    checkOutput("wrap_nwrites", 32'(wrData.size()), 32'd3);
    checkOutput("wrap_addr0", 32'(wrAddr[0]), 32'hFE);
    checkOutput("wrap_addr1", 32'(wrAddr[1]), 32'hFF);
    checkOutput("wrap_addr2", 32'(wrAddr[2]), 32'h00);
    checkOutput("wrap_word_count", 32'(word_count), 32'd3);

    $display("[TB] backpressure with full FIFO");
    clearLog();
    startLoad(8'h40);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(mkAdd(3'(i), 3'd1, 3'd2));
    v = mkAdd(3'd4, 3'd1, 3'd2);
    driveFields(v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_mem_we", 32'(mem_we), 32'd1);
      checkOutput("bp_addr_hold", 32'(mem_addr), 32'h40);
      checkOutput("bp_data_hold", 32'(mem_wdata), 32'(mkAdd(3'd0, 3'd1, 3'd2).word));
      tick();
    end
    mem_ready = 1'b1;
    applyStimulus(v);
    applyStimulus(mkAdd(3'd5, 3'd1, 3'd2));
    finishAndWait("bp");
    checkOutput("bp_nwrites", 32'(wrData.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("bp_data%0d", i), 32'(wrData[i]),
                  32'(mkAdd(3'(i), 3'd1, 3'd2).word));
      checkOutput($sformatf("bp_addr%0d", i), 32'(wrAddr[i]), 32'h40 + 32'(i));
      if (i > 0)
        checkOutput($sformatf("bp_gap%0d", i), 32'(wrCycle[i] - wrCycle[i-1]), 32'd1);
    end

    $display("[TB] reset during flush");
    clearLog();
    startLoad(8'h60);
    mem_ready = 1'b0;
    applyStimulus(mkAdd(3'd1, 3'd1, 3'd1));
    applyStimulus(mkAdd(3'd2, 3'd2, 3'd2));
    finish = 1'b1;
    tick();
    finish = 1'b0;
    @(negedge clk);
    checkOutput("rf_busy_before", 32'(busy), 32'd1);
    checkOutput("rf_we_before", 32'(mem_we), 32'd1);
    tick();
    pulsesBefore = donePulses;
    rst_n = 1'b0;
    #1;
    checkOutput("rf_we_reset", 32'(mem_we), 32'd0);
    checkOutput("rf_busy_reset", 32'(busy), 32'd0);
    checkOutput("rf_addr_reset", 32'(mem_addr), 32'd0);
    checkOutput("rf_count_reset", 32'(word_count), 32'd0);
    repeat (3) tick();
    checkOutput("rf_no_done", 32'(donePulses), 32'(pulsesBefore));
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    clearLog();
    startLoad(8'h70);
    applyStimulus(vecs[2]);
    finishAndWait("rf_after");
    checkOutput("rf_after_nwrites", 32'(wrData.size()), 32'd1);
    checkOutput("rf_after_addr", 32'(wrAddr[0]), 32'h70);
    checkOutput("rf_after_data", 32'(wrData[0]), 32'h5114);
    checkOutput("rf_after_count", 32'(word_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
